// File: rtl/ofifo_drain_if.sv
// Bundle of the drain engine's control, OFIFO read port and PSUM SRAM write port.
// master = drain engine, slave = surrounding controller / OFIFO / SRAM.
interface ofifo_drain_if #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned addr_bw = 4
);
  localparam int unsigned data_w = col * psum_bw;
  localparam int unsigned len_w  = addr_bw + 1;

  logic                start;
  logic [addr_bw-1:0]  base_addr;
  logic [len_w-1:0]    tile_len;
  logic                hold;
  logic                ofifo_valid;
  logic [data_w-1:0]   ofifo_out;
  logic                ofifo_rd;
  logic                sram_cen;
  logic                sram_wen;
  logic [addr_bw-1:0]  sram_addr;
  logic [data_w-1:0]   sram_din;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    input  start, base_addr, tile_len, hold, ofifo_valid, ofifo_out,
    output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_din, busy, done, err
  );

  modport slave (
    output start, base_addr, tile_len, hold, ofifo_valid, ofifo_out,
    input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_din, busy, done, err
  );
endinterface

// File: rtl/ofifo_drain.sv
// Drains one tile of OFIFO words into consecutive PSUM SRAM addresses,
// one pop per cycle when data is available and the arbiter is not holding.
module ofifo_drain #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned addr_bw = 4
) (
  input  logic         clk,
  input  logic         reset,
  ofifo_drain_if.master bus
);
  localparam int unsigned data_w = col * psum_bw;
  localparam int unsigned len_w  = addr_bw + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t             state, state_nx;
  logic [len_w-1:0]   pop_cnt, len_q;
  logic [addr_bw-1:0] base_q;
  logic               pop_c, accept_c, reject_c, last_c;

  logic               cen_q, wen_q, busy_q, done_q, err_q;
  logic [addr_bw-1:0] addr_q;
  logic [data_w-1:0]  din_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and per-cycle decisions; pop is suppressed during reset so the
  // OFIFO never advances for a word that would be thrown away.
  always_comb begin
    state_nx = state;
    pop_c    = 1'b0;
    accept_c = 1'b0;
    reject_c = 1'b0;
    last_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.tile_len != len_w'(0)) begin
            accept_c = 1'b1;
            state_nx = DRAIN;
          end else begin
            reject_c = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!reset && bus.ofifo_valid && !bus.hold && (pop_cnt < len_q)) begin
          pop_c = 1'b1;
          if ((pop_cnt + len_w'(1)) == len_q) begin
            last_c   = 1'b1;
            state_nx = DONE;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Tile bookkeeping and registered SRAM/status outputs (write lands one cycle after pop)
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_cnt <= '0;
      len_q   <= '0;
      base_q  <= '0;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cen_q  <= ~pop_c;
      wen_q  <= ~pop_c;
      done_q <= last_c;
      err_q  <= reject_c;
      busy_q <= (state_nx != IDLE);
      if (accept_c) begin
        base_q  <= bus.base_addr;
        len_q   <= bus.tile_len;
        pop_cnt <= '0;
      end
      if (pop_c) begin
        din_q   <= bus.ofifo_out;
        addr_q  <= base_q + addr_bw'(pop_cnt);
        pop_cnt <= pop_cnt + len_w'(1);
      end
    end
  end

  assign bus.ofifo_rd  = pop_c;
  assign bus.sram_cen  = cen_q;
  assign bus.sram_wen  = wen_q;
  assign bus.sram_addr = addr_q;
  assign bus.sram_din  = din_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ofifo_drain.sv
// Directed bench for ofifo_drain: OFIFO word queue feeds the DUT, and the
// expected SRAM writes are queued when each tile is loaded and popped per write.
module tb_ofifo_drain;
  localparam int unsigned DW = 128;

  typedef struct packed {
    logic [3:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] fifo_q[$];
  wr_t           exp_q[$];

  ofifo_drain_if bus ();
  ofifo_drain dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue a tile's words in the OFIFO model and its expected SRAM writes
  task automatic load_tile(input int base, input int len);
    logic [DW-1:0] w;
    wr_t           e;
    for (int i = 0; i < len; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      fifo_q.push_back(w);
      e.addr = 4'(base + i);
      e.data = w;
      exp_q.push_back(e);
    end
    bus.base_addr = 4'(base);
    bus.tile_len  = 5'(len);
  endtask

  // One clock: drive inputs, check ofifo_rd before the edge, check registered outputs after it
  task automatic step(input logic st, input logic v, input logic h, input logic rst,
                      input logic e_rd, input logic e_done, input logic e_busy, input logic e_err);
    logic rd_seen;
    logic exp_wr;
    wr_t  e;
    bus.start       = st;
    bus.hold        = h;
    reset           = rst;
    bus.ofifo_valid = v && (fifo_q.size() > 0);
    bus.ofifo_out   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    @(negedge clk);
    rd_seen = bus.ofifo_rd;
    chk("ofifo_rd", DW'(rd_seen), DW'(e_rd));
    @(posedge clk);
    #1;
    if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    exp_wr = e_rd && !rst;
    chk("sram_cen", DW'(bus.sram_cen), DW'(!exp_wr));
    chk("sram_wen", DW'(bus.sram_wen), DW'(!exp_wr));
    chk("done", DW'(bus.done), DW'(e_done));
    chk("busy", DW'(bus.busy), DW'(e_busy));
    chk("err", DW'(bus.err), DW'(e_err));
    if (exp_wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard: observed=write expected=no write queued");
      end else begin
        e = exp_q.pop_front();
        chk("sram_addr", DW'(bus.sram_addr), DW'(e.addr));
        chk("sram_din", bus.sram_din, e.data);
      end
    end
    if (rst) begin
      chk("rst_addr", DW'(bus.sram_addr), '0);
      chk("rst_din", bus.sram_din, '0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.hold = 1'b0; bus.ofifo_valid = 1'b0; bus.ofifo_out = '0;
    bus.base_addr = '0; bus.tile_len = '0;
    @(posedge clk);
    #1;
    // reset values
    step(0, 0, 0, 1, 0, 0, 0, 0);

    // base=2 len=4, back-to-back pops, writes at 2..5, done with last write
    load_tile(2, 4);
    step(1, 1, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);

    // address wrap: 14,15,0,1
    load_tile(14, 4);
    step(1, 1, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // bubbles: valid toggling and a 2-cycle hold
    load_tile(7, 3);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // zero-length start rejected
    bus.base_addr = 4'd5;
    bus.tile_len  = 5'd0;
    step(1, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0);

    // start during DRAIN and DONE ignored
    load_tile(3, 2);
    step(1, 1, 0, 0, 0, 0, 1, 0);
    bus.base_addr = 4'd9;
    bus.tile_len  = 5'd5;
    step(1, 1, 0, 0, 1, 0, 1, 0);
    step(1, 1, 0, 0, 1, 1, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // reset the cycle after the 2nd pop of a len=4 tile
    load_tile(0, 4);
    step(1, 1, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0);
    fifo_q.delete();
    exp_q.delete();
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
